// File: rtl/sram_req_ctrl_if.sv
// Command, write-data, read-response and SRAM-side bus of sram_req_ctrl.
// slave  : the controller.
// master : the surrounding environment (command source, SRAM array).
interface sram_req_ctrl_if #(
  parameter int LEN_W = 4
);
  logic             cmd_valid;
  logic             cmd_ready;
  logic             cmd_we;
  logic [22:0]      cmd_addr;
  logic [LEN_W-1:0] cmd_len;

  logic             wd_valid;
  logic             wd_ready;
  logic [63:0]      wd_data;

  logic             rd_valid;
  logic [63:0]      rd_data;
  logic             rd_last;

  logic             err;
  logic             busy;

  logic [22:0]      mem_addr;
  logic [63:0]      mem_wdata;
  logic             mem_we;
  logic [63:0]      mem_rdata;

  modport slave (
    input  cmd_valid, cmd_we, cmd_addr, cmd_len,
    input  wd_valid, wd_data,
    input  mem_rdata,
    output cmd_ready, wd_ready,
    output rd_valid, rd_data, rd_last,
    output err, busy,
    output mem_addr, mem_wdata, mem_we
  );

  modport master (
    output cmd_valid, cmd_we, cmd_addr, cmd_len,
    output wd_valid, wd_data,
    output mem_rdata,
    input  cmd_ready, wd_ready,
    input  rd_valid, rd_data, rd_last,
    input  err, busy,
    input  mem_addr, mem_wdata, mem_we
  );
endinterface

// File: rtl/sram_req_ctrl.sv
// Burst command front-end for the banked 64-bit SRAM array.
//
// state  | meaning
// -------+-----------------------------------------------------------
// IDLE   | waiting for a command; range check done on accept
// WR     | one SRAM write per write-data handshake until burst ends
// RD     | one SRAM read issued per cycle until burst ends
//
// In RD, mem_addr_q itself is the address being issued; it is loaded
// with the start address at accept so the first read address is on the
// bus in the cycle right after the command handshake.
module sram_req_ctrl #(
  parameter int ROW_DEPTH = 4096,
  parameter int LEN_W     = 4
) (
  input  logic            clk_i,
  input  logic            rst_i,
  sram_req_ctrl_if.slave  bus
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WR   = 2'd1,
    S_RD   = 2'd2
  } state_t;

  localparam logic [18:0] ROW_LIMIT = 19'(ROW_DEPTH);

  state_t           state_q, state_d;
  logic [22:0]      beat_addr_q, beat_addr_d;
  logic [LEN_W-1:0] remain_q, remain_d;
  logic [22:0]      mem_addr_q, mem_addr_d;
  logic [63:0]      mem_wdata_q, mem_wdata_d;
  logic             mem_we_q, mem_we_d;
  logic             rd_valid_q, rd_valid_d;
  logic             rd_last_q, rd_last_d;
  logic             err_q, err_d;

  logic             cmd_hs;
  logic             wd_hs;
  logic [23:0]      end_addr;
  logic             range_bad;
  logic             last_beat;

  assign cmd_hs    = bus.cmd_valid & (state_q == S_IDLE);
  assign wd_hs     = bus.wd_valid & (state_q == S_WR);
  assign end_addr  = {1'b0, bus.cmd_addr} + 24'(bus.cmd_len);
  assign range_bad = end_addr[23] | ({1'b0, end_addr[22:5]} >= ROW_LIMIT);
  assign last_beat = (remain_q == '0);

  // state register
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // next-state decode
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (cmd_hs && !range_bad) begin
          state_d = bus.cmd_we ? S_WR : S_RD;
        end
      end
      S_WR: begin
        if (wd_hs && last_beat) begin
          state_d = S_IDLE;
        end
      end
      S_RD: begin
        if (last_beat) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // next values of the registered SRAM-side and response outputs
  always_comb begin
    beat_addr_d = beat_addr_q;
    remain_d    = remain_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_we_d    = 1'b0;
    rd_valid_d  = 1'b0;
    rd_last_d   = 1'b0;
    err_d       = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (cmd_hs) begin
          if (range_bad) begin
            err_d = 1'b1;
          end else begin
            remain_d = bus.cmd_len;
            if (bus.cmd_we) begin
              beat_addr_d = bus.cmd_addr;
            end else begin
              mem_addr_d = bus.cmd_addr;
            end
          end
        end
      end
      S_WR: begin
        if (wd_hs) begin
          mem_we_d    = 1'b1;
          mem_addr_d  = beat_addr_q;
          mem_wdata_d = bus.wd_data;
          beat_addr_d = beat_addr_q + 23'd1;
          if (!last_beat) begin
            remain_d = remain_q - LEN_W'(1);
          end
        end
      end
      S_RD: begin
        rd_valid_d = 1'b1;
        rd_last_d  = last_beat;
        if (!last_beat) begin
          mem_addr_d = mem_addr_q + 23'd1;
          remain_d   = remain_q - LEN_W'(1);
        end
      end
      default: ;
    endcase
  end

  // datapath registers
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      beat_addr_q <= '0;
      remain_q    <= '0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_we_q    <= 1'b0;
      rd_valid_q  <= 1'b0;
      rd_last_q   <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      beat_addr_q <= beat_addr_d;
      remain_q    <= remain_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_we_q    <= mem_we_d;
      rd_valid_q  <= rd_valid_d;
      rd_last_q   <= rd_last_d;
      err_q       <= err_d;
    end
  end

  assign bus.cmd_ready = (state_q == S_IDLE);
  assign bus.wd_ready  = (state_q == S_WR);
  assign bus.busy      = (state_q != S_IDLE) | rd_valid_q;
  assign bus.rd_valid  = rd_valid_q;
  assign bus.rd_last   = rd_last_q;
  assign bus.rd_data   = bus.mem_rdata;
  assign bus.err       = err_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign bus.mem_we    = mem_we_q;

endmodule

// File: tb/tb_sram_req_ctrl.sv
// Bench for sram_req_ctrl: behavioural SRAM array, command-level memory
// model, directed scenarios followed by randomized command traffic.
module tb_sram_req_ctrl;

  localparam int LEN_W     = 4;
  localparam int ROW_DEPTH = 4096;

  logic clk;
  logic rst;

  int total;
  int bad;

  sram_req_ctrl_if #(.LEN_W(LEN_W)) bus ();

  sram_req_ctrl #(.ROW_DEPTH(ROW_DEPTH), .LEN_W(LEN_W)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // behavioural SRAM: registered read, sync reset clears data_out only
  logic [63:0] sram [int];
  always @(posedge clk) begin
    if (rst) begin
      bus.mem_rdata <= '0;
    end else begin
      bus.mem_rdata <= sram.exists(int'(bus.mem_addr)) ? sram[int'(bus.mem_addr)] : 64'd0;
      if (bus.mem_we) sram[int'(bus.mem_addr)] = bus.mem_wdata;
    end
  end

  // reference memory contents as seen from the command side
  logic [63:0] ref_mem [int];
  logic [63:0] wq [$];

  function automatic logic [63:0] ref_rd(input int a);
    return ref_mem.exists(a) ? ref_mem[a] : 64'd0;
  endfunction

  function automatic bit range_ok(input int addr, input int len);
    int last_word;
    last_word = addr + len;
    return (last_word / 32) < ROW_DEPTH;
  endfunction

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (bus.cmd_ready !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) chk("ready_timeout", 0, 1);
  endtask

  task automatic issue(input logic we, input logic [22:0] addr, input int len);
    wait_idle();
    bus.cmd_valid = 1'b1;
    bus.cmd_we    = we;
    bus.cmd_addr  = addr;
    bus.cmd_len   = LEN_W'(len);
    @(posedge clk);
    @(negedge clk);
    bus.cmd_valid = 1'b0;
  endtask

  // gap_pct < 0 gives an alternating 1-0-1 wd_valid pattern
  task automatic do_write(input int addr, input int len, input int nbeats, input int gap_pct);
    int beat;
    int guard;
    logic v;
    issue(1'b1, 23'(addr), len);
    beat  = 0;
    guard = 0;
    while (beat < nbeats && guard < 200) begin
      chk("wd_ready", bus.wd_ready, 1);
      chk("wr_busy", bus.busy, 1);
      if (gap_pct < 0) v = (guard % 2 == 0);
      else             v = ($urandom_range(99) >= gap_pct);
      bus.wd_valid = v;
      bus.wd_data  = wq[beat];
      @(posedge clk);
      @(negedge clk);
      bus.wd_valid = 1'b0;
      chk("wr_mem_we", bus.mem_we, v);
      if (v) begin
        chk("wr_mem_addr", bus.mem_addr, 64'(addr + beat));
        chk("wr_mem_wdata", bus.mem_wdata, wq[beat]);
        ref_mem[addr + beat] = wq[beat];
        beat++;
      end
      guard++;
    end
    if (guard >= 200) chk("wr_timeout", 0, 1);
    if (nbeats == len + 1) chk("wr_done_idle", bus.cmd_ready, 1);
  endtask

  task automatic do_read(input int addr, input int len);
    issue(1'b0, 23'(addr), len);
    chk("rd_lat_early", bus.rd_valid, 0);
    chk("rd_first_addr", bus.mem_addr, 64'(addr));
    chk("rd_busy", bus.busy, 1);
    for (int i = 0; i <= len; i++) begin
      if (i > 0 || 1) @(negedge clk);
      chk("rd_valid", bus.rd_valid, 1);
      chk("rd_data", bus.rd_data, ref_rd(addr + i));
      chk("rd_last", bus.rd_last, (i == len) ? 1 : 0);
      chk("rd_mem_we", bus.mem_we, 0);
    end
    chk("rd_done_idle", bus.cmd_ready, 1);
  endtask

  task automatic do_bad(input logic we, input int addr, input int len);
    issue(we, 23'(addr), len);
    chk("err_pulse", bus.err, 1);
    chk("err_ready", bus.cmd_ready, 1);
    chk("err_mem_we", bus.mem_we, 0);
    chk("err_busy", bus.busy, 0);
    @(negedge clk);
    chk("err_clear", bus.err, 0);
    chk("err_rd_valid", bus.rd_valid, 0);
  endtask

  task automatic idle_check();
    @(negedge clk);
    chk("idle_rd_valid", bus.rd_valid, 0);
    chk("idle_mem_we", bus.mem_we, 0);
    chk("idle_busy", bus.busy, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout got=1 exp=0");
    $fatal(1, "timeout");
  end

  initial begin
    int a;
    int l;
    int row;
    total = 0;
    bad   = 0;
    rst = 1'b1;
    bus.cmd_valid = 1'b0;
    bus.cmd_we    = 1'b0;
    bus.cmd_addr  = '0;
    bus.cmd_len   = '0;
    bus.wd_valid  = 1'b0;
    bus.wd_data   = '0;
    repeat (3) @(negedge clk);
    chk("rst_cmd_ready", bus.cmd_ready, 1);
    chk("rst_wd_ready", bus.wd_ready, 0);
    chk("rst_mem_addr", bus.mem_addr, 0);
    chk("rst_mem_wdata", bus.mem_wdata, 0);
    chk("rst_mem_we", bus.mem_we, 0);
    chk("rst_rd_valid", bus.rd_valid, 0);
    chk("rst_err", bus.err, 0);
    chk("rst_busy", bus.busy, 0);
    rst = 1'b0;
    @(negedge clk);

    // single write then read
    wq = {64'hDEADBEEF_01234567};
    do_write(32'h21, 0, 1, 0);
    do_read(32'h21, 0);
    idle_check();

    // 16-beat burst across bank 31 -> next row, gapped write data
    wq.delete();
    for (int i = 0; i < 16; i++) wq.push_back(64'(i));
    do_write(32'h1E, 15, 16, -1);
    do_read(32'h1E, 15);
    idle_check();

    // range errors and the last legal word
    do_bad(1'b1, 32'h01FFFF, 1);
    do_bad(1'b0, 32'h7FFFFF, 0);
    wq = {64'hA5A5_0000_FFFF_5A5A};
    do_write(32'h01FFFF, 0, 1, 0);
    do_read(32'h01FFFF, 0);

    // read burst directly followed by write to its first word
    wq = {64'h11, 64'h22, 64'h33, 64'h44};
    do_write(32'h40, 3, 4, 0);
    do_read(32'h40, 3);
    wq = {64'hCAFE_F00D_0000_0040};
    do_write(32'h40, 0, 1, 0);
    do_read(32'h40, 0);
    idle_check();

    // reset after two of eight read beats issued
    issue(1'b0, 23'h100, 7);
    @(posedge clk);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("rrst_rd_valid", bus.rd_valid, 0);
    chk("rrst_busy", bus.busy, 0);
    chk("rrst_mem_we", bus.mem_we, 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rrst_ready", bus.cmd_ready, 1);
    chk("rrst_no_beat", bus.rd_valid, 0);

    // reset during a write burst after three of five beats committed
    wq = {64'h501, 64'h502, 64'h503, 64'h504, 64'h505};
    do_write(32'h200, 4, 5, 0);
    wq = {64'h601, 64'h602, 64'h603, 64'h604, 64'h605};
    do_write(32'h200, 4, 3, 0);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("wrst_mem_we", bus.mem_we, 0);
    chk("wrst_busy", bus.busy, 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("wrst_ready", bus.cmd_ready, 1);
    do_read(32'h200, 4);
    chk("wrst_keep3", ref_rd(32'h203), 64'h504);

    // randomized traffic, concentrated on a few rows so reads hit writes
    for (int n = 0; n < 60; n++) begin
      case ($urandom_range(5))
        0: row = 0;
        1: row = 1;
        2: row = 4094;
        3: row = 4095;
        4: row = $urandom_range(8191);
        default: row = 2;
      endcase
      a = row * 32 + int'($urandom_range(31));
      l = int'($urandom_range(15));
      if (!range_ok(a, l)) begin
        do_bad($urandom_range(1) == 1, a, l);
      end else if ($urandom_range(1) == 1) begin
        wq.delete();
        for (int i = 0; i <= l; i++) wq.push_back({$urandom, $urandom});
        do_write(a, l, l + 1, 30);
      end else begin
        do_read(a, l);
      end
      if ($urandom_range(3) == 0) idle_check();
    end
    idle_check();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
